regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the 24-bit core datapath.
- Provides NUM_RD combinational read ports and two write ports: wr0 for ALU writeback, wr1 for memory/load writeback.
- Includes write-to-read bypass and a per-register pending (scoreboard) bit, so decode can detect registers awaiting an outstanding load.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- DATA_W, 24, register width in bits.
- NUM_REGS, 16, number of architectural registers.
- ADDR_W, $clog2(NUM_REGS), register index width.
- NUM_RD, 3, number of read ports.
- ZERO_REG_EN, 1, 1 = register 0 is hardwired to zero.
- BYPASS_EN, 1, 1 = same-cycle write data is forwarded to matching reads.
- RST_VALUES, {NUM_REGS{DATA_W'h0}} with idx1=24'h00020, idx2=24'h1B831, idx3=24'h40000, idx4=24'h37042, idx5=24'h391A8, packed per-register reset values (entry i at bits [i*DATA_W +: DATA_W]).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, same packing as rd_addr.
- rd_busy  out  NUM_RD  port i reads a pending register.
- wr0_en  in  1  ALU write enable.
- wr0_addr  in  ADDR_W  ALU write index.
- wr0_data  in  DATA_W  ALU write data.
- wr1_en  in  1  load write enable; also clears pending.
- wr1_addr  in  ADDR_W  load write index.
- wr1_data  in  DATA_W  load write data.
- sb_set_en  in  1  mark register pending (load issued).
- sb_set_addr  in  ADDR_W  index to mark pending.
- sb_busy  out  NUM_REGS  pending bit per register.
- wr_conflict  out  1  registered pulse: both writes targeted the same index last cycle.

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
  - On reset: reg[i] <= RST_VALUES entry i; all sb_busy = 0; wr_conflict = 0.
  - rd_data reflects the reset values combinationally.
  - A reset asserted mid-operation discards any in-flight write and all pending bits.
- Writes (rising clk):
  - wrN_en=1 updates reg[wrN_addr] at the edge.
  - Both ports enabled with equal addresses: wr0 wins, and wr_conflict is 1 for the following cycle only.
  - Different addresses: both writes complete.
  - Writes with out-of-range addresses (NUM_REGS not a power of 2) are ignored.
- Zero register (ZERO_REG_EN=1):
  - Reads of index 0 return 0.
  - Writes to index 0 are dropped.
  - sb_set to index 0 is ignored; sb_busy[0] is always 0.
  - wr_conflict is still flagged for equal addresses at index 0.
- Reads are combinational with 0-cycle latency. Per port, priority is:
  1. zero register;
  2. bypass from wr0 (BYPASS_EN and wr0_en and addr match);
  3. bypass from wr1;
  4. stored value.
- BYPASS_EN=0: reads return the stored value only; new data is visible the cycle after the write.
- Scoreboard (rising clk):
  - sb_set_en sets busy[sb_set_addr].
  - wr1_en clears busy[wr1_addr].
  - Set and clear on the same index in the same cycle: set wins (new load issued).
  - wr0 writes never clear busy.
  - Setting an already-busy register keeps it 1.
- rd_busy[i] = busy[rd_addr_i], except it is 0 when BYPASS_EN=1 and wr1_en=1 with wr1_addr == rd_addr_i in that cycle (value forwarded).
  - rd_busy is 0 for index 0 when ZERO_REG_EN=1.
- Fully synchronous apart from rst. No internal stalling; the consumer acts on rd_busy.

Test Plan:
- Reset check: assert rst asynchronously between edges, then read idx 0..5 on port 0 -> 0, 24'h00020, 24'h1B831, 24'h40000, 24'h37042, 24'h391A8; sb_busy = 16'h0000.
- Write then read: wr0 idx 7 = 24'hABCDEF; same cycle rd_addr0 = 7 -> rd_data0 = 24'hABCDEF (bypass); next cycle stored value is also 24'hABCDEF. With BYPASS_EN=0, the same-cycle read returns the old value 24'h000000.
- Write conflict: wr0 and wr1 both to idx 9, data 24'h111111 / 24'h222222 -> next cycle reg9 = 24'h111111, wr_conflict = 1 for one cycle, then 0.
- Zero register: wr0 idx 0 = 24'hFFFFFF and sb_set idx 0 -> read idx 0 = 24'h000000, sb_busy[0] = 0.
- Scoreboard:
  - sb_set idx 4 -> sb_busy[4] = 1, and rd_addr1 = 4 gives rd_busy[1] = 1.
  - Later, wr1 idx 4 = 24'h000123 with rd_addr1 = 4 -> rd_busy[1] = 0 and rd_data1 = 24'h000123 that cycle; sb_busy[4] = 0 next cycle.
  - Simultaneous sb_set idx 4 and wr1 idx 4 -> sb_busy[4] stays 1.
- Reset mid-operation: wr0 idx 3 = 24'h00AAAA, sb_set idx 6, rst pulses before the edge -> reg3 = 24'h40000, sb_busy[6] = 0.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass and load scoreboard
//
// Purpose: NUM_RD combinational read ports, two write ports (wr0 = ALU, wr1 =
// load writeback), same-cycle write-to-read forwarding and a per-register
// pending bit that marks registers waiting on an outstanding load.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   rd_addr       packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   rd_data       packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy       port i reads a register still pending a load
//   wr0_*         ALU writeback (wins on equal-address collision)
//   wr1_*         load writeback; also clears the pending bit
//   sb_set_*      mark a register pending when a load issues
//   sb_busy       pending bit per register
//   wr_conflict   one-cycle pulse after both writes hit the same index

module regfile_mp #(
  parameter int DATA_W      = 24,
  parameter int NUM_REGS    = 16,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int NUM_RD      = 3,
  parameter int ZERO_REG_EN = 1,
  parameter int BYPASS_EN   = 1,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALUES = {
    {((NUM_REGS - 6) * DATA_W){1'b0}},
    DATA_W'(24'h391A8), DATA_W'(24'h37042), DATA_W'(24'h40000),
    DATA_W'(24'h1B831), DATA_W'(24'h00020), DATA_W'(24'h00000)
  }
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       sb_set_en,
  input  logic [ADDR_W-1:0]          sb_set_addr,
  output logic [NUM_REGS-1:0]        sb_busy,
  output logic                       wr_conflict
);

  // One extra bit so NUM_REGS itself is representable for the range compare.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  function automatic logic is_zero_idx(input logic [ADDR_W-1:0] a);
    return (ZERO_REG_EN != 0) && (a == '0);
  endfunction

  // A write (or pending mark) only lands on a real, non-hardwired register.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return in_range(a) && !is_zero_idx(a);
  endfunction

  logic wr0_ok, wr1_ok, sb_ok;
  assign wr0_ok = wr0_en && writable(wr0_addr);
  assign wr1_ok = wr1_en && writable(wr1_addr);
  assign sb_ok  = sb_set_en && writable(sb_set_addr);

  // wr1 is applied first so a colliding wr0 overwrites it and wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RST_VALUES[i*DATA_W +: DATA_W];
      end
    end else begin
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
    end
  end

  // Clear before set: a new load issued in the same cycle as the previous
  // load's writeback keeps the register pending.
  always_comb begin
    busy_next = busy;
    if (wr1_ok) busy_next[wr1_addr] = 1'b0;
    if (sb_ok)  busy_next[sb_set_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy        <= busy_next;
      // Flagged on raw address equality, including index 0.
      wr_conflict <= wr0_en && wr1_en && (wr0_addr == wr1_addr);
    end
  end

  assign sb_busy = busy;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero, rng, hit0, hit1;

    assign a    = rd_addr[p*ADDR_W +: ADDR_W];
    assign zero = is_zero_idx(a);
    assign rng  = in_range(a);
    assign hit0 = (BYPASS_EN != 0) && wr0_ok && (wr0_addr == a);
    assign hit1 = (BYPASS_EN != 0) && wr1_ok && (wr1_addr == a);

    assign rd_data[p*DATA_W +: DATA_W] = zero ? '0       :
                                         hit0 ? wr0_data :
                                         hit1 ? wr1_data :
                                         rng  ? regs[a]  : '0;

    // The load result is being forwarded this cycle, so it is no longer a hazard.
    assign rd_busy[p] = !zero && !hit1 && rng && busy[a];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (bypass and no-bypass builds)

module tb_regfile_mp;
  localparam int DW = 24, NREG = 16, AW = 4, NRD = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]    rd_busy, rd_busy_nb;
  logic              wr0_en, wr1_en, sb_set_en;
  logic [AW-1:0]     wr0_addr, wr1_addr, sb_set_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic [NREG-1:0]   sb_busy, sb_busy_nb;
  logic              wr_conflict, wr_conflict_nb;

  regfile_mp u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .sb_busy(sb_busy), .wr_conflict(wr_conflict)
  );

  regfile_mp #(.BYPASS_EN(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .sb_busy(sb_busy_nb), .wr_conflict(wr_conflict_nb)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state as the programmer sees it.
  logic [DW-1:0] m_regs [NREG];
  logic          m_busy [NREG];
  logic          m_conf;
  logic [DW-1:0] rst_vals [6] = '{24'h000000, 24'h000020, 24'h01B831,
                                  24'h040000, 24'h037042, 24'h0391A8};

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = (i < 6) ? rst_vals[i] : '0;
      m_busy[i] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && wr0_en && wr0_addr == a) return wr0_data;
    if (byp && wr1_en && wr1_addr == a) return wr1_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && wr1_en && wr1_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [NREG-1:0] exp_sb();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Advance one clock and apply the architectural effect of the current inputs.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_conf = wr0_en && wr1_en && (wr0_addr == wr1_addr);
      if (wr1_en && wr1_addr != 0) m_regs[wr1_addr] = wr1_data;
      if (wr0_en && wr0_addr != 0) m_regs[wr0_addr] = wr0_data;
      if (wr1_en) m_busy[wr1_addr] = 1'b0;
      if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic clear_inputs();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    sb_set_en = 0; sb_set_addr = '0;
    rd_addr = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sb_busy !== 16'h0000) begin
      errors++; $display("FAIL reset_sb_busy: got %h expected %h", sb_busy, 16'h0000);
    end
    checks++;
    if (wr_conflict !== 1'b0) begin
      errors++; $display("FAIL reset_wr_conflict: got %b expected 0", wr_conflict);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      rd_addr[0 +: AW] = AW'(i);
      #1;
      checks++;
      if (rd_data[0 +: DW] !== rst_vals[i]) begin
        errors++; $display("FAIL reset_value idx %0d: got %h expected %h", i, rd_data[0 +: DW], rst_vals[i]);
      end
    end
  endtask

  task automatic test_write_read();
    clear_inputs();
    wr0_en = 1; wr0_addr = 4'd7; wr0_data = 24'hABCDEF;
    rd_addr[0 +: AW] = 4'd7;
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 24'hABCDEF) begin
      errors++; $display("FAIL bypass_wr0: got %h expected %h", rd_data[0 +: DW], 24'hABCDEF);
    end
    checks++;
    if (rd_data_nb[0 +: DW] !== 24'h000000) begin
      errors++; $display("FAIL nobypass_old: got %h expected %h", rd_data_nb[0 +: DW], 24'h000000);
    end
    tick();
    wr0_en = 0;
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 24'hABCDEF) begin
      errors++; $display("FAIL stored_wr0: got %h expected %h", rd_data[0 +: DW], 24'hABCDEF);
    end
    checks++;
    if (rd_data_nb[0 +: DW] !== 24'hABCDEF) begin
      errors++; $display("FAIL nobypass_next: got %h expected %h", rd_data_nb[0 +: DW], 24'hABCDEF);
    end
  endtask

  task automatic test_conflict();
    clear_inputs();
    wr0_en = 1; wr0_addr = 4'd9; wr0_data = 24'h111111;
    wr1_en = 1; wr1_addr = 4'd9; wr1_data = 24'h222222;
    rd_addr[0 +: AW] = 4'd9;
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 24'h111111) begin
      errors++; $display("FAIL conflict_bypass: got %h expected %h", rd_data[0 +: DW], 24'h111111);
    end
    tick();
    checks++;
    if (wr_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_pulse: got %b expected 1", wr_conflict);
    end
    clear_inputs();
    rd_addr[0 +: AW] = 4'd9;
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 24'h111111) begin
      errors++; $display("FAIL conflict_stored: got %h expected %h", rd_data[0 +: DW], 24'h111111);
    end
    tick();
    checks++;
    if (wr_conflict !== 1'b0) begin
      errors++; $display("FAIL conflict_clear: got %b expected 0", wr_conflict);
    end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    wr0_en = 1; wr0_addr = 4'd0; wr0_data = 24'hFFFFFF;
    sb_set_en = 1; sb_set_addr = 4'd0;
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 24'h000000) begin
      errors++; $display("FAIL zero_same_cycle: got %h expected %h", rd_data[0 +: DW], 24'h000000);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 24'h000000) begin
      errors++; $display("FAIL zero_read: got %h expected %h", rd_data[0 +: DW], 24'h000000);
    end
    checks++;
    if (sb_busy[0] !== 1'b0 || rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL zero_busy: got %b/%b expected 0/0", sb_busy[0], rd_busy[0]);
    end
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    sb_set_en = 1; sb_set_addr = 4'd4;
    tick();
    clear_inputs();
    rd_addr[AW +: AW] = 4'd4;
    #1;
    checks++;
    if (sb_busy[4] !== 1'b1 || rd_busy[1] !== 1'b1) begin
      errors++; $display("FAIL sb_set: got %b/%b expected 1/1", sb_busy[4], rd_busy[1]);
    end
    // wr0 must not clear a pending load.
    wr0_en = 1; wr0_addr = 4'd4; wr0_data = 24'h00BEEF;
    tick();
    wr0_en = 0;
    checks++;
    if (sb_busy[4] !== 1'b1) begin
      errors++; $display("FAIL sb_wr0_noclear: got %b expected 1", sb_busy[4]);
    end
    wr1_en = 1; wr1_addr = 4'd4; wr1_data = 24'h000123;
    #1;
    checks++;
    if (rd_busy[1] !== 1'b0 || rd_data[DW +: DW] !== 24'h000123) begin
      errors++; $display("FAIL sb_forward: got %b/%h expected 0/%h", rd_busy[1], rd_data[DW +: DW], 24'h000123);
    end
    checks++;
    if (rd_busy_nb[1] !== 1'b1) begin
      errors++; $display("FAIL sb_nobypass_busy: got %b expected 1", rd_busy_nb[1]);
    end
    tick();
    wr1_en = 0;
    checks++;
    if (sb_busy[4] !== 1'b0) begin
      errors++; $display("FAIL sb_clear: got %b expected 0", sb_busy[4]);
    end
    sb_set_en = 1; sb_set_addr = 4'd4;
    wr1_en = 1; wr1_addr = 4'd4; wr1_data = 24'h000456;
    tick();
    checks++;
    if (sb_busy[4] !== 1'b1) begin
      errors++; $display("FAIL sb_set_wins: got %b expected 1", sb_busy[4]);
    end
    wr1_en = 0;
    tick();
    clear_inputs();
    checks++;
    if (sb_busy[4] !== 1'b1) begin
      errors++; $display("FAIL sb_reset_keep: got %b expected 1", sb_busy[4]);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    sb_set_en = 1; sb_set_addr = 4'd6;
    tick();
    checks++;
    if (sb_busy[6] !== 1'b1) begin
      errors++; $display("FAIL mid_pre_busy: got %b expected 1", sb_busy[6]);
    end
    wr0_en = 1; wr0_addr = 4'd3; wr0_data = 24'h00AAAA;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (sb_busy !== 16'h0000) begin
      errors++; $display("FAIL mid_async_sb: got %h expected %h", sb_busy, 16'h0000);
    end
    @(posedge clk);
    #1;
    clear_inputs();
    rst = 1'b0;
    model_reset();
    rd_addr[0 +: AW] = 4'd3;
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 24'h040000) begin
      errors++; $display("FAIL mid_reg3: got %h expected %h", rd_data[0 +: DW], 24'h040000);
    end
    checks++;
    if (sb_busy[6] !== 1'b0) begin
      errors++; $display("FAIL mid_sb6: got %b expected 0", sb_busy[6]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr0_en = 1'($urandom_range(0, 1));
      wr0_addr = 4'($urandom_range(0, 15));
      wr0_data = 24'($urandom);
      wr1_en = 1'($urandom_range(0, 1));
      wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 4'($urandom_range(0, 15));
      wr1_data = 24'($urandom);
      sb_set_en = 1'($urandom_range(0, 1));
      sb_set_addr = ($urandom_range(0, 3) == 0) ? wr1_addr : 4'($urandom_range(0, 15));
      for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = 4'($urandom_range(0, 15));
      #1;
      for (int p = 0; p < NRD; p++) begin
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        checks++;
        if (rd_data[p*DW +: DW] !== exp_rd(a, 1'b1) || rd_busy[p] !== exp_busy(a, 1'b1)) begin
          errors++; $display("FAIL rand_read port %0d idx %0d: got %h/%b expected %h/%b",
                             p, a, rd_data[p*DW +: DW], rd_busy[p], exp_rd(a, 1'b1), exp_busy(a, 1'b1));
        end
        checks++;
        if (rd_data_nb[p*DW +: DW] !== exp_rd(a, 1'b0) || rd_busy_nb[p] !== exp_busy(a, 1'b0)) begin
          errors++; $display("FAIL rand_read_nb port %0d idx %0d: got %h/%b expected %h/%b",
                             p, a, rd_data_nb[p*DW +: DW], rd_busy_nb[p], exp_rd(a, 1'b0), exp_busy(a, 1'b0));
        end
      end
      tick();
      checks++;
      if (sb_busy !== exp_sb() || wr_conflict !== m_conf) begin
        errors++; $display("FAIL rand_state: got %h/%b expected %h/%b", sb_busy, wr_conflict, exp_sb(), m_conf);
      end
      checks++;
      if (sb_busy_nb !== exp_sb() || wr_conflict_nb !== m_conf) begin
        errors++; $display("FAIL rand_state_nb: got %h/%b expected %h/%b", sb_busy_nb, wr_conflict_nb, exp_sb(), m_conf);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_write_read();
    test_conflict();
    test_zero_reg();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
